// File: rtl/bcd_time_counter.sv
// HH:MM:SS timekeeper counting BCD digits from a clk prescaler, with set buttons,
// a validated two-stage load, 12/24 h display and wrap strobes. Alarm: BCD_TIME_ALARM_EN.
module bcd_time_counter #(
  parameter int TICK_DIV = 12,
  parameter int PRE_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       hour_inc,
  input  logic       min_inc,
  input  logic       set_valid,
  input  logic [7:0] set_h,
  input  logic [7:0] set_m,
  input  logic [7:0] set_s,
  output logic       set_ready,
  output logic       set_err,
  output logic [3:0] h1,
  output logic [3:0] h2,
  output logic [3:0] m1,
  output logic [3:0] m2,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap
`ifdef BCD_TIME_ALARM_EN
  ,
  input  logic       alarm_on,
  input  logic [7:0] alarm_h,
  input  logic [7:0] alarm_m,
  output logic       alarm
`endif
);

  // Load handshake: a request is accepted when set_valid & set_ready (LD_IDLE);
  // the following cycle (LD_CHECK, set_ready=0) validates and commits or rejects.
  typedef enum logic {LD_IDLE, LD_CHECK} ld_state_t;

  ld_state_t        ld_state, ld_state_n;
  logic [PRE_W-1:0] pre, pre_n;
  logic [3:0]       ht, ho, mt, mo, st, so;
  logic [3:0]       ht_n, ho_n, mt_n, mo_n, st_n, so_n;
  logic [7:0]       cap_h, cap_m, cap_s;
  logic             hour_prev, min_prev;
  logic             tick_pend, tick_pend_n;
  logic             sec_tick_n, day_wrap_n;
  logic             tick_evt, hour_edge, min_edge, want_tick;
  logic             busy, cap_ok, commit;
  logic [4:0]       hour_bin, hour_12;

  function automatic logic [7:0] sixty_next(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd9) return {t, o + 4'd1};
    else           return {(t == 4'd5) ? 4'd0 : t + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] hour_next(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd2 && o == 4'd3) return 8'h00;
    else if (o == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, o + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] max_t,
                                  input logic [3:0] max_o_at_top);
    if (v[7:4] > max_t || v[3:0] > 4'd9) return 1'b0;
    if (v[7:4] == max_t && v[3:0] > max_o_at_top) return 1'b0;
    return 1'b1;
  endfunction

  assign tick_evt  = en && (pre == PRE_W'(TICK_DIV - 1));
  assign hour_edge = hour_inc & ~hour_prev;
  assign min_edge  = min_inc & ~min_prev;
  assign want_tick = tick_evt | tick_pend;
  assign busy      = (ld_state == LD_CHECK);
  assign cap_ok    = bcd_ok(cap_h, 4'd2, 4'd3) && bcd_ok(cap_m, 4'd5, 4'd9) &&
                     bcd_ok(cap_s, 4'd5, 4'd9);
  assign commit    = busy & cap_ok;
  assign set_err   = busy & ~cap_ok;
  assign set_ready = (ld_state == LD_IDLE);

  always_comb begin
    ld_state_n = ld_state;
    case (ld_state)
      LD_IDLE:  if (set_valid) ld_state_n = LD_CHECK;
      LD_CHECK: ld_state_n = LD_IDLE;
      default:  ld_state_n = LD_IDLE;
    endcase
  end

  // One time update per cycle; buttons never carry, ticks ripple through all digits.
  always_comb begin
    {ht_n, ho_n} = {ht, ho};
    {mt_n, mo_n} = {mt, mo};
    {st_n, so_n} = {st, so};
    day_wrap_n   = 1'b0;
    if (commit) begin
      {ht_n, ho_n} = cap_h;
      {mt_n, mo_n} = cap_m;
      {st_n, so_n} = cap_s;
    end else if (hour_edge) begin
      {ht_n, ho_n} = hour_next(ht, ho);
    end else if (min_edge) begin
      {mt_n, mo_n} = sixty_next(mt, mo);
    end else if (want_tick) begin
      {st_n, so_n} = sixty_next(st, so);
      if ({st, so} == 8'h59) begin
        {mt_n, mo_n} = sixty_next(mt, mo);
        if ({mt, mo} == 8'h59) begin
          {ht_n, ho_n} = hour_next(ht, ho);
          day_wrap_n   = ({ht, ho} == 8'h23);
        end
      end
    end
  end

  always_comb begin
    pre_n       = pre;
    tick_pend_n = tick_pend & tick_evt;
    sec_tick_n  = tick_evt & ~commit;
    if (commit) begin
      pre_n       = '0;
      tick_pend_n = 1'b0;
    end else begin
      if (en) pre_n = tick_evt ? '0 : pre + PRE_W'(1);
      if (hour_edge || min_edge) tick_pend_n = tick_pend | tick_evt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state  <= LD_IDLE;
      pre       <= '0;
      {ht, ho}  <= 8'h00;
      {mt, mo}  <= 8'h00;
      {st, so}  <= 8'h00;
      cap_h     <= 8'h00;
      cap_m     <= 8'h00;
      cap_s     <= 8'h00;
      hour_prev <= 1'b0;
      min_prev  <= 1'b0;
      tick_pend <= 1'b0;
      sec_tick  <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      ld_state  <= ld_state_n;
      pre       <= pre_n;
      {ht, ho}  <= {ht_n, ho_n};
      {mt, mo}  <= {mt_n, mo_n};
      {st, so}  <= {st_n, so_n};
      hour_prev <= hour_inc;
      min_prev  <= min_inc;
      tick_pend <= tick_pend_n;
      sec_tick  <= sec_tick_n;
      day_wrap  <= day_wrap_n;
      if (ld_state == LD_IDLE && set_valid) begin
        cap_h <= set_h;
        cap_m <= set_m;
        cap_s <= set_s;
      end
    end
  end

  // Display path is purely combinational so a mode change shows immediately.
  assign hour_bin = 5'(ht) * 5'd10 + 5'(ho);
  assign m1 = mt;
  assign m2 = mo;
  assign s1 = st;
  assign s2 = so;

  always_comb begin
    h1      = ht;
    h2      = ho;
    pm      = 1'b0;
    hour_12 = hour_bin;
    if (mode_12h) begin
      pm = (hour_bin >= 5'd12);
      if (hour_bin == 5'd0)      hour_12 = 5'd12;
      else if (hour_bin > 5'd12) hour_12 = hour_bin - 5'd12;
      if (hour_12 >= 5'd10) begin
        h1 = 4'd1;
        h2 = 4'(hour_12 - 5'd10);
      end else begin
        h1 = 4'd0;
        h2 = hour_12[3:0];
      end
    end
  end

`ifdef BCD_TIME_ALARM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        alarm <= 1'b0;
    else if (!alarm_on)                               alarm <= 1'b0;
    else if ({ht, ho} == alarm_h && {mt, mo} == alarm_m &&
             {st, so} == 8'h00)                       alarm <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter: directed scenarios plus a randomized run
// against a seconds-of-day reference model.
module tb_bcd_time_counter;
  localparam int TICK_DIV = 12;

  logic       clk = 1'b0;
  logic       reset, en, mode_12h, hour_inc, min_inc, set_valid;
  logic [7:0] set_h, set_m, set_s;
  logic       set_ready, set_err, pm, sec_tick, day_wrap;
  logic [3:0] h1, h2, m1, m2, s1, s2;
  logic [28:0] obs;

  int err_cnt = 0;
  int chk_cnt = 0;

  // reference model state: time as seconds of day
  int         m_time, m_pre;
  bit         m_pend, m_ph, m_pmin, m_busy, m_tick, m_wrap;
  logic [7:0] m_ch, m_cm, m_cs;

`ifdef BCD_TIME_ALARM_EN
  logic alarm;
  logic alarm_on = 1'b0;
  logic [7:0] alarm_h = 8'h00, alarm_m = 8'h00;
`endif

  bcd_time_counter #(.TICK_DIV(TICK_DIV), .PRE_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .mode_12h(mode_12h),
    .hour_inc(hour_inc), .min_inc(min_inc), .set_valid(set_valid),
    .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .set_ready(set_ready), .set_err(set_err),
    .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .pm(pm), .sec_tick(sec_tick), .day_wrap(day_wrap)
`ifdef BCD_TIME_ALARM_EN
    , .alarm_on(alarm_on), .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {h1, h2, m1, m2, s1, s2, pm, sec_tick, day_wrap, set_ready, set_err};

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b, input int maxv);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd_val(b) <= maxv);
  endfunction

  function automatic bit cap_ok();
    return bcd_ok(m_ch, 23) && bcd_ok(m_cm, 59) && bcd_ok(m_cs, 59);
  endfunction

  function automatic logic [28:0] exp_vec();
    int hh, mm, ss, hd;
    bit p;
    hh = m_time / 3600;
    mm = (m_time / 60) % 60;
    ss = m_time % 60;
    hd = hh;
    p  = 1'b0;
    if (mode_12h) begin
      p  = (hh >= 12);
      hd = hh % 12;
      if (hd == 0) hd = 12;
    end
    return {4'(hd / 10), 4'(hd % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            p, m_tick, m_wrap, !m_busy, m_busy && !cap_ok()};
  endfunction

  task automatic model_reset();
    m_time = 0; m_pre = 0; m_pend = 0; m_ph = 0; m_pmin = 0;
    m_busy = 0; m_tick = 0; m_wrap = 0;
    m_ch = 8'h00; m_cm = 8'h00; m_cs = 8'h00;
  endtask

  // Applies the inputs present before the coming edge to the model.
  task automatic model_step();
    bit hedge, medge, tick, commit;
    int mm;
    hedge  = hour_inc && !m_ph;
    medge  = min_inc && !m_pmin;
    tick   = en && (m_pre == TICK_DIV - 1);
    commit = m_busy && cap_ok();
    m_tick = tick && !commit;
    m_wrap = 1'b0;
    if (commit) begin
      m_time = bcd_val(m_ch) * 3600 + bcd_val(m_cm) * 60 + bcd_val(m_cs);
      m_pre  = 0;
      m_pend = 0;
    end else begin
      if (hedge) begin
        m_time = ((m_time / 3600 + 1) % 24) * 3600 + m_time % 3600;
        m_pend = m_pend || tick;
      end else if (medge) begin
        mm     = (m_time / 60) % 60;
        m_time = m_time - mm * 60 + ((mm + 1) % 60) * 60;
        m_pend = m_pend || tick;
      end else if (tick || m_pend) begin
        m_wrap = (m_time == 86399);
        m_time = (m_time + 1) % 86400;
        m_pend = m_pend && tick;
      end
      if (en) m_pre = tick ? 0 : m_pre + 1;
    end
    if (m_busy) m_busy = 1'b0;
    else if (set_valid) begin
      m_busy = 1'b1;
      m_ch = set_h; m_cm = set_m; m_cs = set_s;
    end
    m_ph   = hour_inc;
    m_pmin = min_inc;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_valid = 1'b1; set_h = h; set_m = m; set_s = s;
    cyc();
    set_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    en = 1'b1; mode_12h = 1'b0; hour_inc = 1'b0; min_inc = 1'b0;
    set_valid = 1'b0; set_h = 8'h00; set_m = 8'h00; set_s = 8'h00;
    do_reset();
    chk_cnt++;
    if (obs !== 29'h2) begin
      err_cnt++; $display("FAIL reset_24h: got %h expected %h", obs, 29'h2);
    end
    mode_12h = 1'b1;
    #1;
    chk_cnt++;
    if ({h1, h2, pm} !== {4'd1, 4'd2, 1'b0}) begin
      err_cnt++; $display("FAIL reset_12h: got h=%0d%0d pm=%b expected 12 pm=0", h1, h2, pm);
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_count();
    int ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (sec_tick) ticks++;
    end
    chk_cnt++;
    if ({m1, m2, s1, s2} !== 16'h0001 || ticks != 1) begin
      err_cnt++; $display("FAIL count_12: got %h%h%h%h ticks=%0d expected 0001 ticks=1", m1, m2, s1, s2, ticks);
    end
    for (int i = 12; i < 720; i++) cyc();
    chk_cnt++;
    if ({h1, h2, m1, m2, s1, s2} !== 24'h000100) begin
      err_cnt++; $display("FAIL count_720: got %h%h:%h%h:%h%h expected 00:01:00", h1, h2, m1, m2, s1, s2);
    end
    chk_cnt++;
    if (obs !== exp_vec()) begin
      err_cnt++; $display("FAIL count_model: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_day_wrap();
    int wraps = 0;
    en = 1'b1; mode_12h = 1'b0;
    load_time(8'h23, 8'h59, 8'h58);
    chk_cnt++;
    if ({h1, h2, m1, m2, s1, s2} !== 24'h235958) begin
      err_cnt++; $display("FAIL load_235958: got %h%h%h%h%h%h expected 235958", h1, h2, m1, m2, s1, s2);
    end
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (day_wrap) wraps++;
    end
    chk_cnt++;
    if ({h1, h2, m1, m2, s1, s2, pm} !== {24'h000000, 1'b0} || wraps != 1) begin
      err_cnt++; $display("FAIL day_wrap: got %h%h%h%h%h%h wraps=%0d expected 000000 wraps=1", h1, h2, m1, m2, s1, s2, wraps);
    end
    mode_12h = 1'b1;
    #1;
    chk_cnt++;
    if ({h1, h2, pm} !== {4'd1, 4'd2, 1'b0}) begin
      err_cnt++; $display("FAIL wrap_12h: got h=%0d%0d pm=%b expected 12 pm=0", h1, h2, pm);
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_reject();
    en = 1'b0;
    load_time(8'h12, 8'h34, 8'h56);
    set_valid = 1'b1; set_h = 8'h24; set_m = 8'h00; set_s = 8'h00;
    cyc();
    set_valid = 1'b0;
    chk_cnt++;
    if ({set_ready, set_err} !== 2'b01) begin
      err_cnt++; $display("FAIL reject_cycle_b: got ready=%b err=%b expected ready=0 err=1", set_ready, set_err);
    end
    cyc();
    chk_cnt++;
    if ({h1, h2, m1, m2, s1, s2, set_ready, set_err} !== {24'h123456, 2'b10}) begin
      err_cnt++; $display("FAIL reject_after: got %h%h%h%h%h%h ready=%b err=%b expected 123456 ready=1 err=0", h1, h2, m1, m2, s1, s2, set_ready, set_err);
    end
  endtask

  task automatic test_buttons();
    en = 1'b0;
    load_time(8'h10, 8'h30, 8'h00);
    hour_inc = 1'b1;
    for (int i = 0; i < 50; i++) cyc();
    hour_inc = 1'b0;
    cyc();
    chk_cnt++;
    if ({h1, h2, m1, m2} !== 16'h1130) begin
      err_cnt++; $display("FAIL hour_hold: got %h%h:%h%h expected 11:30", h1, h2, m1, m2);
    end
    load_time(8'h11, 8'h59, 8'h00);
    min_inc = 1'b1;
    cyc();
    min_inc = 1'b0;
    cyc();
    chk_cnt++;
    if ({h1, h2, m1, m2, s1, s2} !== 24'h110000) begin
      err_cnt++; $display("FAIL min_wrap: got %h%h:%h%h:%h%h expected 11:00:00", h1, h2, m1, m2, s1, s2);
    end
  endtask

  task automatic test_collision();
    en = 1'b1;
    load_time(8'h05, 8'h10, 8'h20);
    for (int i = 0; i < TICK_DIV - 1; i++) cyc();
    min_inc = 1'b1;
    cyc();
    min_inc = 1'b0;
    chk_cnt++;
    if ({m1, m2, s1, s2, sec_tick} !== {16'h1120, 1'b1}) begin
      err_cnt++; $display("FAIL collide_edge: got %h%h:%h%h tick=%b expected 11:20 tick=1", m1, m2, s1, s2, sec_tick);
    end
    cyc();
    chk_cnt++;
    if ({h1, h2, m1, m2, s1, s2} !== 24'h051121) begin
      err_cnt++; $display("FAIL collide_defer: got %h%h:%h%h:%h%h expected 05:11:21", h1, h2, m1, m2, s1, s2);
    end
  endtask

  task automatic test_reset_mid_load();
    en = 1'b1;
    set_valid = 1'b1; set_h = 8'h07; set_m = 8'h29; set_s = 8'h59;
    cyc();
    chk_cnt++;
    if (set_ready !== 1'b0) begin
      err_cnt++; $display("FAIL midload_accept: got ready=%b expected 0", set_ready);
    end
    set_valid = 1'b0;
    do_reset();
    chk_cnt++;
    if (obs !== 29'h2) begin
      err_cnt++; $display("FAIL midload_reset: got %h expected %h", obs, 29'h2);
    end
    cyc();
    chk_cnt++;
    if (obs !== exp_vec() || {h1, h2, m1, m2, s1, s2} !== 24'h0) begin
      err_cnt++; $display("FAIL midload_after: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int hv;
    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) hour_inc = ~hour_inc;
      if ($urandom_range(0, 5) == 0) min_inc  = ~min_inc;
      if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
      set_valid = ($urandom_range(0, 29) == 0);
      hv    = $urandom_range(0, 23);
      set_h = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : {4'(hv / 10), 4'(hv % 10)};
      hv    = $urandom_range(0, 59);
      set_m = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : {4'(hv / 10), 4'(hv % 10)};
      hv    = $urandom_range(0, 59);
      set_s = {4'(hv / 10), 4'(hv % 10)};
      cyc();
      chk_cnt++;
      if (obs !== exp_vec()) begin
        err_cnt++;
        bad++;
        if (bad <= 10) $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    hour_inc = 1'b0; min_inc = 1'b0; set_valid = 1'b0; mode_12h = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_day_wrap();
    test_reject();
    test_buttons();
    test_collision();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
